// File: rtl/div_result_bcd.sv
// div_result_bcd: converts one quotient/remainder pair from div_16bit into packed BCD.
// It uses a sequential double-dabble that shifts one bit per clock, and it holds
// one conversion at a time.
//
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   : input handshake; in_ready is high only in IDLE
//   quotient, remainder   : DATA_W-bit operands
//   in_dz                 : divisor was zero; the operands are ignored
//   out_valid / out_ready : output handshake; the result is held until it is accepted
//   quo_bcd, rem_bcd      : packed BCD results, digit 0 in [3:0]
//   out_err               : the result came from a divide-by-zero (all digits 4'hE)
//   busy                  : high in SHIFT or DONE
//
// Optional feature macro: DIV_BCD_LEADZERO_BLANK_EN
//   When this macro is defined, leading zero digits (never digit 0) read 4'hF.
//   The divide-by-zero pattern is never blanked.
module div_result_bcd #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     quotient,
    input  logic [DATA_W-1:0]     remainder,
    input  logic                  in_dz,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   quo_bcd,
    output logic [4*DIGITS-1:0]   rem_bcd,
    output logic                  out_err,
    output logic                  busy
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [DATA_W-1:0]  q_sh, q_sh_d, r_sh, r_sh_d;
    logic [BCD_W-1:0]   q_acc, q_acc_d, r_acc, r_acc_d;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_d;
    logic               in_ready_d, out_valid_d, out_err_d, busy_d;
    logic [BCD_W-1:0]   quo_bcd_d, rem_bcd_d;
    logic [BCD_W-1:0]   q_step, r_step;

    // One double-dabble step: add 3 to every digit >= 5 with no carry between digits,
    // then shift in the next operand bit.
    function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] acc, input logic bit_in);
        logic [BCD_W-1:0] adj;
        logic [3:0]       d;
        adj = acc;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d = acc[4*i +: 4];
            if (d >= 4'd5) d = d + 4'd3;
            adj[4*i +: 4] = d;
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

`ifdef DIV_BCD_LEADZERO_BLANK_EN
    // Replace leading zero digits with 4'hF, scanning from the most significant digit.
    // Digit 0 is always kept.
    function automatic logic [BCD_W-1:0] blank_lz(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             lead;
        r    = v;
        lead = 1'b1;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            if (lead && (v[4*i +: 4] == 4'd0)) r[4*i +: 4] = 4'hF;
            else                               lead = 1'b0;
        end
        return r;
    endfunction
`endif

    assign q_step = dabble(q_acc, q_sh[DATA_W-1]);
    assign r_step = dabble(r_acc, r_sh[DATA_W-1]);

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            q_sh      <= '0;
            r_sh      <= '0;
            q_acc     <= '0;
            r_acc     <= '0;
            bit_cnt   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            busy      <= 1'b0;
            quo_bcd   <= '0;
            rem_bcd   <= '0;
        end else begin
            state     <= state_d;
            q_sh      <= q_sh_d;
            r_sh      <= r_sh_d;
            q_acc     <= q_acc_d;
            r_acc     <= r_acc_d;
            bit_cnt   <= bit_cnt_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_err   <= out_err_d;
            busy      <= busy_d;
            quo_bcd   <= quo_bcd_d;
            rem_bcd   <= rem_bcd_d;
        end
    end

    // Next-state and next-register values
    always_comb begin
        state_d   = state;
        q_sh_d    = q_sh;
        r_sh_d    = r_sh;
        q_acc_d   = q_acc;
        r_acc_d   = r_acc;
        bit_cnt_d = bit_cnt;
        out_err_d = out_err;
        quo_bcd_d = quo_bcd;
        rem_bcd_d = rem_bcd;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    q_sh_d    = quotient;
                    r_sh_d    = remainder;
                    q_acc_d   = '0;
                    r_acc_d   = '0;
                    bit_cnt_d = '0;
                    out_err_d = in_dz;
                    if (in_dz) begin
                        state_d   = DONE;
                        quo_bcd_d = {DIGITS{4'hE}};
                        rem_bcd_d = {DIGITS{4'hE}};
                    end else begin
                        state_d   = SHIFT;
                    end
                end
            end
            SHIFT: begin
                q_acc_d   = q_step;
                r_acc_d   = r_step;
                q_sh_d    = {q_sh[DATA_W-2:0], 1'b0};
                r_sh_d    = {r_sh[DATA_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt + CNT_W'(1);
                if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                    state_d   = DONE;
`ifdef DIV_BCD_LEADZERO_BLANK_EN
                    quo_bcd_d = blank_lz(q_step);
                    rem_bcd_d = blank_lz(r_step);
`else
                    quo_bcd_d = q_step;
                    rem_bcd_d = r_step;
`endif
                end
            end
            DONE: begin
                if (out_valid && out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // out_valid follows one edge after DONE entry and drops on the handshake edge
        out_valid_d = (state == DONE) && (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd. All expected values are hand-computed constants.
module tb_div_result_bcd;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [15:0] quotient, remainder;
    logic        in_dz;
    logic        out_valid, out_ready;
    logic [19:0] quo_bcd, rem_bcd;
    logic        out_err, busy;

    int n_cmp = 0;
    int n_err = 0;

`ifdef DIV_BCD_LEADZERO_BLANK_EN
    localparam logic [19:0] E_1234  = 20'hF1234;
    localparam logic [19:0] E_56    = 20'hFFF56;
    localparam logic [19:0] E_0     = 20'hFFFF0;
    localparam logic [19:0] E_7     = 20'hFFFF7;
    localparam logic [19:0] E_100   = 20'hFF100;
    localparam logic [19:0] E_9     = 20'hFFFF9;
    localparam logic [19:0] E_9999  = 20'hF9999;
`else
    localparam logic [19:0] E_1234  = 20'h01234;
    localparam logic [19:0] E_56    = 20'h00056;
    localparam logic [19:0] E_0     = 20'h00000;
    localparam logic [19:0] E_7     = 20'h00007;
    localparam logic [19:0] E_100   = 20'h00100;
    localparam logic [19:0] E_9     = 20'h00009;
    localparam logic [19:0] E_9999  = 20'h09999;
`endif
    localparam logic [19:0] E_10000 = 20'h10000;
    localparam logic [19:0] E_65535 = 20'h65535;
    localparam logic [19:0] E_DZ    = 20'hEEEEE;

    div_result_bcd #(.DATA_W(16), .DIGITS(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .in_dz     (in_dz),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quo_bcd   (quo_bcd),
        .rem_bcd   (rem_bcd),
        .out_err   (out_err),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept one pair, measure the latency, check the result, optionally apply
    // backpressure with a competing request, then complete the output handshake.
    task automatic run(input string name, input logic [15:0] q, input logic [15:0] r,
                       input logic dz, input logic [19:0] eq, input logic [19:0] er,
                       input logic eerr, input int elat, input int hold);
        int lat;
        quotient  = q;
        remainder = r;
        in_dz     = dz;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        check({name, "_busy"}, 32'(busy), 32'd1);
        check({name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(elat));
        check({name, "_quo"}, 32'(quo_bcd), 32'(eq));
        check({name, "_rem"}, 32'(rem_bcd), 32'(er));
        check({name, "_err"}, 32'(out_err), 32'(eerr));
        if (hold > 0) begin
            quotient  = 16'd999;
            remainder = 16'd1;
            in_dz     = 1'b0;
            in_valid  = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check({name, "_hold_quo"}, 32'(quo_bcd), 32'(eq));
                check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
                check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            end
            check({name, "_hold_rem"}, 32'(rem_bcd), 32'(er));
            check({name, "_hold_err"}, 32'(out_err), 32'(eerr));
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
        check({name, "_busy_clear"}, 32'(busy), 32'd0);
        if (hold > 0) begin
            repeat (3) @(posedge clk);
            #1;
            check({name, "_no_accept"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_dz     = 1'b0;
        quotient  = '0;
        remainder = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quo", 32'(quo_bcd), 32'd0);
        check("rst_rem", 32'(rem_bcd), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run("v1234",  16'd1234,  16'd56,    1'b0, E_1234,  E_56,    1'b0, 17, 0);
        run("vmax",   16'hFFFF,  16'hFFFF,  1'b0, E_65535, E_65535, 1'b0, 17, 0);
        run("vzero",  16'd0,     16'd0,     1'b0, E_0,     E_0,     1'b0, 17, 0);
        run("vdz",    16'h1234,  16'h1234,  1'b1, E_DZ,    E_DZ,    1'b1, 1,  0);
        run("v100",   16'd100,   16'd9,     1'b0, E_100,   E_9,     1'b0, 17, 0);
        run("vbp",    16'd9999,  16'd10000, 1'b0, E_9999,  E_10000, 1'b0, 17, 10);

        // Reset in the middle of a conversion
        quotient  = 16'd5000;
        remainder = 16'd321;
        in_dz     = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_quo", 32'(quo_bcd), 32'd0);
        check("midrst_rem", 32'(rem_bcd), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run("v7", 16'd7, 16'd0, 1'b0, E_7, E_0, 1'b0, 17, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
